// File: rtl/bus_master_if.sv
// CPU-side bus initiator: turns a held CPU request into one bus cycle, stalls the
// pipeline until ack, returns read data, and aborts on flush or a no-ack timeout.
module bus_master_if #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8,
   parameter int DW      = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          stall_i,
   input  logic          flush_i,
   input  logic          cpu_ce_i,
   input  logic [DW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_data_i,
   input  logic          cpu_we_i,
   input  logic [3:0]    cpu_sel_i,
   output logic [DW-1:0] cpu_data_o,
   output logic          stallreq_o,
   output logic          err_o,
   input  logic [DW-1:0] bus_data_i,
   input  logic          bus_ack_i,
   output logic [DW-1:0] bus_addr_o,
   output logic [DW-1:0] bus_data_o,
   output logic [3:0]    bus_sel_o,
   output logic          bus_we_o,
   output logic          bus_stb_o,
   output logic          bus_cyc_o
);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] BUSY       = 2'd1;
   localparam logic [1:0] WAIT_STALL = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0] addr_q, addr_d, wdat_q, wdat_d, rd_q, rd_d;
   logic [3:0]    sel_q, sel_d;
   logic          we_q, we_d, act_q, act_d, err_q, err_d;
   logic          timeout_hit, clr_bus;

   assign timeout_hit = (state_q == BUSY) && !bus_ack_i && (cnt_q == TO_W'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      sel_d   = sel_q;
      we_d    = we_q;
      act_d   = act_q;
      rd_d    = rd_q;
      err_d   = 1'b0;
      clr_bus = 1'b0;
      if (flush_i) begin
         clr_bus = 1'b1;
         rd_d    = '0;
         cnt_d   = '0;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (cpu_ce_i) begin
               addr_d  = cpu_addr_i;
               wdat_d  = cpu_data_i;
               sel_d   = cpu_sel_i;
               we_d    = cpu_we_i;
               act_d   = 1'b1;
               cnt_d   = '0;
               state_d = BUSY;
            end
            BUSY: begin
               if (bus_ack_i) begin
                  clr_bus = 1'b1;
                  if (!cpu_we_i) rd_d = bus_data_i;
                  state_d = stall_i ? WAIT_STALL : IDLE;
               end else if (timeout_hit) begin
                  // Abort: the core sees zero data plus a one-cycle error pulse.
                  clr_bus = 1'b1;
                  rd_d    = '0;
                  err_d   = 1'b1;
                  state_d = stall_i ? WAIT_STALL : IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            WAIT_STALL: if (!stall_i) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      if (clr_bus) begin
         addr_d = '0;
         wdat_d = '0;
         sel_d  = '0;
         we_d   = 1'b0;
         act_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdat_q  <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         act_q   <= 1'b0;
         rd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         act_q   <= act_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      stallreq_o = 1'b0;
      cpu_data_o = rd_q;
      case (state_q)
         IDLE: stallreq_o = cpu_ce_i & ~flush_i;
         BUSY: begin
            stallreq_o = ~(bus_ack_i | timeout_hit) & ~flush_i;
            // Read data is forwarded in the ack cycle so the core need not wait a cycle.
            cpu_data_o = (bus_ack_i && !cpu_we_i) ? bus_data_i : '0;
         end
         default: stallreq_o = 1'b0;
      endcase
   end

   assign bus_addr_o = addr_q;
   assign bus_data_o = wdat_q;
   assign bus_sel_o  = sel_q;
   assign bus_we_o   = we_q;
   assign bus_stb_o  = act_q;
   assign bus_cyc_o  = act_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: transaction-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_bus_master_if;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, ce = 1'b0, we = 1'b0, ack = 1'b0;
   logic [31:0] addr = '0, wdata = '0, bdata = '0;
   logic [3:0]  sel = '0;
   logic [31:0] cpu_data, baddr, bwdata;
   logic [3:0]  bsel;
   logic        stallreq, err, bwe, bstb, bcyc;

   int n_tests = 0, n_fail = 0;

   bus_master_if #(.TIMEOUT(TO), .TO_W(8)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .cpu_ce_i(ce),
      .cpu_addr_i(addr), .cpu_data_i(wdata), .cpu_we_i(we), .cpu_sel_i(sel),
      .cpu_data_o(cpu_data), .stallreq_o(stallreq), .err_o(err),
      .bus_data_i(bdata), .bus_ack_i(ack), .bus_addr_o(baddr), .bus_data_o(bwdata),
      .bus_sel_o(bsel), .bus_we_o(bwe), .bus_stb_o(bstb), .bus_cyc_o(bcyc));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an outstanding transfer, how long it has waited, the held
   // request, the read-back buffer, a pending error pulse and a stall hold.
   logic        m_ok = 1'b0, m_act = 1'b0, m_hold = 1'b0, m_err = 1'b0;
   int          m_waited = 0;
   logic [31:0] m_addr = '0, m_data = '0, m_rd = '0;
   logic [3:0]  m_sel = '0;
   logic        m_we = 1'b0;

   function automatic logic m_timeout();
      return m_act && !ack && (m_waited == TO - 1);
   endfunction

   always @(negedge clk) if (m_ok) begin
      logic        e_stall;
      logic [31:0] e_data;
      if (m_act) begin
         e_stall = !(ack || m_timeout()) && !flush;
         e_data  = (ack && !we) ? bdata : 32'h0;
      end else begin
         e_stall = m_hold ? 1'b0 : (ce && !flush);
         e_data  = m_rd;
      end
      chk("stallreq", {31'b0, stallreq}, {31'b0, e_stall});
      chk("cpu_data", cpu_data, e_data);
      chk("err", {31'b0, err}, {31'b0, m_err});
      chk("cyc", {31'b0, bcyc}, {31'b0, m_act});
      chk("stb", {31'b0, bstb}, {31'b0, m_act});
      chk("bus_addr", baddr, m_act ? m_addr : 32'h0);
      chk("bus_data", bwdata, m_act ? m_data : 32'h0);
      chk("bus_sel", {28'b0, bsel}, {28'b0, m_act ? m_sel : 4'h0});
      chk("bus_we", {31'b0, bwe}, {31'b0, m_act & m_we});
   end

   always @(posedge clk) begin
      logic to;
      to = m_timeout();
      if (rst) begin
         m_ok = 1'b1; m_act = 1'b0; m_hold = 1'b0; m_err = 1'b0; m_rd = '0;
      end else if (flush) begin
         m_act = 1'b0; m_hold = 1'b0; m_err = 1'b0; m_rd = '0;
      end else if (m_act) begin
         m_err = 1'b0;
         if (ack) begin
            if (!we) m_rd = bdata;
            m_act = 1'b0; m_hold = stall;
         end else if (to) begin
            m_rd = '0; m_err = 1'b1; m_act = 1'b0; m_hold = stall;
         end else m_waited++;
      end else if (m_hold) begin
         m_err = 1'b0;
         if (!stall) m_hold = 1'b0;
      end else begin
         m_err = 1'b0;
         if (ce) begin
            m_act = 1'b1; m_waited = 0;
            m_addr = addr; m_data = wdata; m_sel = sel; m_we = we;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
      ce = 1'b1; addr = a; wdata = d; we = w; sel = s;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cyc", {31'b0, bcyc}, 32'h0);
      chk("rst_data", cpu_data, 32'h0);

      // Single read, ack on the third BUSY cycle.
      req(32'h0000_1000, 32'h0, 1'b0, 4'hF);
      @(negedge clk); chk("rd_idle_stallreq", {31'b0, stallreq}, 32'h1);
      tick();
      @(negedge clk); chk("rd_b1_cyc", {31'b0, bcyc}, 32'h1); chk("rd_b1_addr", baddr, 32'h0000_1000);
      tick(); tick();
      ack = 1'b1; bdata = 32'hDEAD_BEEF;
      @(negedge clk); chk("rd_ack_fwd", cpu_data, 32'hDEAD_BEEF); chk("rd_ack_stallreq", {31'b0, stallreq}, 32'h0);
      tick();
      ce = 1'b0; ack = 1'b0; bdata = '0;
      @(negedge clk); chk("rd_buf", cpu_data, 32'hDEAD_BEEF); chk("rd_done_cyc", {31'b0, bcyc}, 32'h0);

      // Write, ack in the first BUSY cycle; read buffer must survive.
      req(32'h0000_2000, 32'h1234_5678, 1'b1, 4'b0011);
      tick();
      ack = 1'b1;
      @(negedge clk); chk("wr_we", {31'b0, bwe}, 32'h1); chk("wr_sel", {28'b0, bsel}, 32'h3);
      chk("wr_data", bwdata, 32'h1234_5678);
      tick();
      ce = 1'b0; ack = 1'b0; we = 1'b0;
      @(negedge clk); chk("wr_clr_sel", {28'b0, bsel}, 32'h0); chk("wr_rdbuf", cpu_data, 32'hDEAD_BEEF);

      // Ack while stalled -> hold, then release.
      req(32'h0000_3000, 32'h0, 1'b0, 4'hF);
      tick();
      ack = 1'b1; bdata = 32'hCAFE_F00D; stall = 1'b1;
      tick();
      ack = 1'b0; bdata = '0;
      @(negedge clk); chk("ws_stallreq", {31'b0, stallreq}, 32'h0); chk("ws_data", cpu_data, 32'hCAFE_F00D);
      ce = 1'b0;
      tick();
      stall = 1'b0;
      tick();
      ce = 1'b1;
      @(negedge clk); chk("ws_back_idle", {31'b0, stallreq}, 32'h1);
      ce = 1'b0;
      tick();

      // No ack: abort after TO BUSY cycles.
      req(32'h0000_4000, 32'h0, 1'b0, 4'hF);
      tick(); tick(); tick(); tick();
      @(negedge clk); chk("to_stallreq", {31'b0, stallreq}, 32'h0); chk("to_cyc_last", {31'b0, bcyc}, 32'h1);
      tick();
      ce = 1'b0;
      @(negedge clk); chk("to_err", {31'b0, err}, 32'h1); chk("to_data", cpu_data, 32'h0);
      chk("to_cyc", {31'b0, bcyc}, 32'h0);
      tick();
      @(negedge clk); chk("to_err_pulse", {31'b0, err}, 32'h0);

      // Flush in the ack cycle discards data and clears the buffer.
      req(32'h0000_5000, 32'h0, 1'b0, 4'hF);
      tick();
      ack = 1'b1; bdata = 32'h1111_2222;
      tick();
      ack = 1'b0;
      req(32'h0000_5004, 32'h0, 1'b0, 4'hF);
      tick();
      ack = 1'b1; bdata = 32'h3333_4444; flush = 1'b1;
      @(negedge clk); chk("fl_stallreq", {31'b0, stallreq}, 32'h0);
      tick();
      flush = 1'b0; ack = 1'b0; ce = 1'b0; bdata = '0;
      @(negedge clk); chk("fl_rdbuf", cpu_data, 32'h0); chk("fl_err", {31'b0, err}, 32'h0);

      // Reset mid-BUSY, then a normal read.
      req(32'h0000_6000, 32'hAAAA_0000, 1'b1, 4'hC);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; ce = 1'b0;
      @(negedge clk); chk("rst_mid_cyc", {31'b0, bcyc}, 32'h0); chk("rst_mid_addr", baddr, 32'h0);
      req(32'h0000_7000, 32'h0, 1'b0, 4'hF);
      tick(); tick();
      ack = 1'b1; bdata = 32'h55AA_55AA;
      tick();
      ack = 1'b0; bdata = '0;
      // Back-to-back write in the IDLE cycle right after completion.
      req(32'h0000_7004, 32'h0BAD_F00D, 1'b1, 4'h1);
      @(negedge clk); chk("post_rst_rd", cpu_data, 32'h55AA_55AA);
      tick();
      @(negedge clk); chk("b2b_cyc", {31'b0, bcyc}, 32'h1); chk("b2b_addr", baddr, 32'h0000_7004);
      ack = 1'b1;
      tick();
      ack = 1'b0; ce = 1'b0; we = 1'b0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
